// File: rtl/jb_dfe_int_delay_sched.sv
// jb_dfe_int_delay_sched: applies per-antenna integer delay targets on boundary strobes, one antenna per strobe, round-robin.
// Define JB_DFE_INT_DLY_STEP_LIMIT_EN to limit each applied change to MAX_STEP.
module jb_dfe_int_delay_sched #(
  parameter int N_ANTENNAS = 4,
  parameter int DLY_W = 7,
  parameter int MAX_DLY = 63,
  parameter int MAX_STEP = 1,
  parameter int SETTLE_CYC = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [$clog2(N_ANTENNAS)-1:0] cfg_ant,
  input  logic signed [DLY_W-1:0] cfg_delay,
  input  logic sync_pulse,
  input  logic err_clr,
  output logic [N_ANTENNAS*DLY_W-1:0] int_delay,
  output logic [N_ANTENNAS-1:0] upd_done,
  output logic dly_busy,
  output logic err_clamp
);
  localparam int AW = $clog2(N_ANTENNAS);
  localparam int CW = $clog2(SETTLE_CYC + 1);
`ifdef JB_DFE_INT_DLY_STEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  // Without limiting, a step bound of MAX_DLY can never be exceeded, so the target loads directly.
  localparam logic signed [DLY_W:0] LIM = (DLY_W+1)'(LIMIT_EN ? MAX_STEP : MAX_DLY);
  localparam logic signed [DLY_W-1:0] MAXD = DLY_W'(MAX_DLY);
  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;
  state_t state, state_nx;
  logic signed [DLY_W-1:0] dly [N_ANTENNAS];
  logic signed [DLY_W-1:0] tgt [N_ANTENNAS];
  logic [N_ANTENNAS-1:0] pending;
  logic [AW-1:0] rr_ptr, sel, j;
  logic found, wr, clamp_lo, clamp_hi;
  logic [CW-1:0] cnt;
  logic signed [DLY_W-1:0] cval, nxt;
  logic signed [DLY_W:0] cur_x, diff;

  for (genvar g = 0; g < N_ANTENNAS; g++) begin : g_out
    assign int_delay[g*DLY_W +: DLY_W] = dly[g];
  end

  always_comb begin
    found = 1'b0;
    sel = '0;
    j = '0;
    for (int i = 0; i < N_ANTENNAS; i++) begin
      j = AW'((int'(rr_ptr) + i) % N_ANTENNAS);
      if (!found && pending[j]) begin
        found = 1'b1;
        sel = j;
      end
    end
  end

  always_comb begin
    cur_x = {dly[sel][DLY_W-1], dly[sel]};
    diff = {tgt[sel][DLY_W-1], tgt[sel]} - cur_x;
    nxt = diff > LIM ? DLY_W'(cur_x + LIM) : diff < -LIM ? DLY_W'(cur_x - LIM) : tgt[sel];
    cfg_ready = state != STEP;
    wr = cfg_valid && cfg_ready;
    clamp_lo = cfg_delay < 0;
    clamp_hi = cfg_delay > MAXD;
    cval = clamp_lo ? '0 : clamp_hi ? MAXD : cfg_delay;
    state_nx = state == IDLE ? (sync_pulse && |pending ? STEP : IDLE) :
               state == STEP ? SETTLE : (cnt == '0 ? IDLE : SETTLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      pending <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      upd_done <= '0;
      dly_busy <= 1'b0;
      err_clamp <= 1'b0;
      for (int i = 0; i < N_ANTENNAS; i++) begin
        dly[i] <= '0;
        tgt[i] <= '0;
      end
    end else begin
      state <= state_nx;
      dly_busy <= state_nx != IDLE;
      upd_done <= '0;
      err_clamp <= (wr && (clamp_lo || clamp_hi)) ? 1'b1 : err_clr ? 1'b0 : err_clamp;
      if (wr) begin
        tgt[cfg_ant] <= cval;
        pending[cfg_ant] <= cval != dly[cfg_ant];
      end
      // Writes are refused during STEP, so the step never races a pending update.
      if (state == STEP) begin
        cnt <= CW'(SETTLE_CYC - 1);
        if (found) begin
          dly[sel] <= nxt;
          rr_ptr <= sel == AW'(N_ANTENNAS - 1) ? '0 : sel + 1'b1;
          if (nxt == tgt[sel]) begin
            pending[sel] <= 1'b0;
            upd_done[sel] <= 1'b1;
          end
        end
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jb_dfe_int_delay_sched.sv
// tb_jb_dfe_int_delay_sched: randomized and directed bench with a cycle-indexed behavioural model of the scheduler.
module tb_jb_dfe_int_delay_sched;
  localparam int N = 4;
  localparam int DW = 7;
  localparam int S = 16;
`ifdef JB_DFE_INT_DLY_STEP_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
`else
  localparam bit LIM_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetn, cfg_valid, cfg_ready, sync_pulse, err_clr, dly_busy, err_clamp;
  logic [1:0] cfg_ant;
  logic signed [DW-1:0] cfg_delay;
  logic [N*DW-1:0] int_delay;
  logic [N-1:0] upd_done;
  int checks = 0, failures = 0;
  int m_tgt[N], m_cur[N];
  bit [N-1:0] m_pend, m_upd;
  bit m_err;
  int m_rr, n = 0, step_n = -1, idle_n = -1;

  jb_dfe_int_delay_sched dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ant(cfg_ant), .cfg_delay(cfg_delay), .sync_pulse(sync_pulse), .err_clr(err_clr),
    .int_delay(int_delay), .upd_done(upd_done), .dly_busy(dly_busy), .err_clamp(err_clamp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int dly_of(input int i);
    logic signed [DW-1:0] v;
    v = int_delay[i*DW +: DW];
    return int'(v);
  endfunction

  // Model: period n follows the n-th edge; a STEP occupies period step_n, busy spans [step_n, idle_n).
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
      m_pend = '0; m_upd = '0; m_err = 0; m_rr = 0; step_n = -1; idle_n = -1;
    end else begin
      int p, v, k, d, lim;
      bit in_step, idle_p, clamped;
      p = n;
      in_step = (p == step_n);
      idle_p = !(p >= step_n && p < idle_n);
      m_upd = '0;
      if (idle_p && sync_pulse && m_pend != 0) begin
        step_n = p + 1;
        idle_n = p + 2 + S;
      end
      clamped = 0;
      if (cfg_valid && !in_step) begin
        v = int'(cfg_delay);
        if (v < 0) begin v = 0; clamped = 1; end
        if (v > 63) begin v = 63; clamped = 1; end
        m_tgt[cfg_ant] = v;
        m_pend[cfg_ant] = (v != m_cur[cfg_ant]);
      end
      if (clamped) m_err = 1;
      else if (err_clr) m_err = 0;
      if (in_step) begin
        k = -1;
        for (int i = 0; i < N; i++)
          if (k < 0 && m_pend[(m_rr + i) % N]) k = (m_rr + i) % N;
        if (k >= 0) begin
          lim = LIM_EN ? 1 : 1000;
          d = m_tgt[k] - m_cur[k];
          m_cur[k] = d > lim ? m_cur[k] + lim : d < -lim ? m_cur[k] - lim : m_tgt[k];
          if (m_cur[k] == m_tgt[k]) begin m_pend[k] = 0; m_upd[k] = 1; end
          m_rr = (k + 1) % N;
        end
      end
      n = n + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (resetn) begin
      logic [N*DW-1:0] ev;
      for (int i = 0; i < N; i++) ev[i*DW +: DW] = DW'(m_cur[i]);
      chk("int_delay", int_delay, ev);
      chk("upd_done", upd_done, m_upd);
      chk("dly_busy", dly_busy, (n >= step_n && n < idle_n));
      chk("cfg_ready", cfg_ready, (n != step_n));
      chk("err_clamp", err_clamp, m_err);
    end
  end

  task automatic wr(input int a, input int v, input bit clr);
    @(negedge clk);
    cfg_valid = 1; cfg_ant = 2'(a); cfg_delay = DW'(v); err_clr = clr;
    @(negedge clk);
    cfg_valid = 0; err_clr = 0;
  endtask

  task automatic pulse_sync;
    @(negedge clk); sync_pulse = 1;
    @(negedge clk); sync_pulse = 0;
  endtask

  initial begin
    resetn = 0; cfg_valid = 0; cfg_ant = 0; cfg_delay = 0; sync_pulse = 0; err_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_int_delay", int_delay, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", dly_busy, 0);
    chk("rst_err", err_clamp, 0);
    @(negedge clk); resetn = 1;
    wr(0, 40, 0);
    pulse_sync;
    chk("step_ready_low", cfg_ready, 0);
    chk("step_busy", dly_busy, 1);
    @(posedge clk); #1;
    chk("ant0_delay", dly_of(0), LIM_EN ? 1 : 40);
    chk("ant0_done", upd_done, LIM_EN ? 0 : 1);
    repeat (S) @(posedge clk);
    #1;
    chk("settle_end_idle", dly_busy, 0);
    wr(0, 40, 0);
    pulse_sync;
    chk("rewrite_same_busy", dly_busy, LIM_EN ? 1 : 0);
    repeat (S + 4) @(negedge clk);
    wr(1, -4, 0);
    chk("clamp_sets_err", err_clamp, 1);
    wr(1, -4, 1);
    chk("clamp_beats_clr", err_clamp, 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("clr_clears_err", err_clamp, 0);
    wr(3, 7, 0);
    pulse_sync;
    repeat (5) @(posedge clk);
    #1;
    chk("ant3_delay", dly_of(3), LIM_EN ? 1 : 7);
    chk("settle_busy", dly_busy, 1);
    #2 resetn = 0;
    #1;
    chk("async_int_delay", int_delay, 0);
    chk("async_busy", dly_busy, 0);
    chk("async_ready", cfg_ready, 1);
    @(negedge clk); resetn = 1;
    pulse_sync;
    chk("pending_cleared", dly_busy, 0);
    repeat (3000) begin
      @(negedge clk);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ant = 2'($urandom_range(0, 3));
      cfg_delay = ($urandom_range(0, 9) == 0) ? DW'($urandom) : DW'($urandom_range(0, 63));
      sync_pulse = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    cfg_valid = 0; sync_pulse = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jb_dfe_int_delay_sched.md
# jb_dfe_int_delay_sched

Schedules runtime changes of the per-antenna integer time delay applied by the DFE integer-delay FIFO-adjust datapath. Configuration writes set per-antenna target delays. The block applies them only on slot/symbol boundary strobes, one antenna per boundary in round-robin order, and holds a settle window between steps so the FIFO-adjust stage can re-align. It runs in the 4x DFE clock domain and drives the `int_delay` vector consumed by the delay datapath.

## Interface
- `N_ANTENNAS`, 4, number of antenna delay channels
- `DLY_W`, 7, signed delay width
- `MAX_DLY`, 63, largest legal delay; legal range is 0..MAX_DLY
- `MAX_STEP`, 1, largest delay change per applied step (only used with step limiting)
- `SETTLE_CYC`, 16, settle window length in clk cycles, ≥1
- `clk`  in  1  4x DFE clock (491.52 MHz)
- `resetn`  in  1  reset; asynchronous assert, active-low
- `cfg_valid`  in  1  config write request
- `cfg_ready`  out  1  config write accept
- `cfg_ant`  in  $clog2(N_ANTENNAS)  target antenna index
- `cfg_delay`  in  DLY_W signed  requested delay
- `sync_pulse`  in  1  one-cycle boundary strobe
- `err_clr`  in  1  clears `err_clamp`
- `int_delay`  out  DLY_W signed ×N_ANTENNAS  applied delay per antenna
- `upd_done`  out  N_ANTENNAS  one-cycle pulse when an antenna reaches its target
- `dly_busy`  out  1  high whenever FSM ≠ IDLE
- `err_clamp`  out  1  sticky; a write was clamped

## Operation
- Reset values: `int_delay` all 0, targets 0, pending 0, `rr_ptr` 0, FSM IDLE, settle counter 0, `upd_done` 0, `err_clamp` 0, `dly_busy` 0, `cfg_ready` 1.
- `cfg_ready` = (FSM ≠ STEP).
- Accepted write (`cfg_valid && cfg_ready`):
  - Clamp: below 0 → 0; above MAX_DLY → MAX_DLY. Either clamp sets `err_clamp`.
  - Store the clamped value as target[cfg_ant], overwriting any earlier target.
  - pending[cfg_ant] = (clamped ≠ int_delay[cfg_ant]). A write equal to the current delay clears pending and produces no `upd_done`.
- `err_clamp`: set and `err_clr` in the same cycle → set wins.
- FSM states: IDLE, STEP, SETTLE.
  - IDLE → STEP when `sync_pulse` is high and |pending. Otherwise the strobe is ignored.
  - STEP (one cycle): select the first pending antenna k, searching upward from `rr_ptr` with wrap-around.
    - int_delay[k] moves toward target[k] by min(|diff|, MAX_STEP).
    - `rr_ptr` ← (k+1) mod N_ANTENNAS.
    - If int_delay[k] reaches target[k], clear pending[k] and pulse upd_done[k] in the next cycle.
    - Counter ← SETTLE_CYC−1; go to SETTLE.
  - SETTLE: decrement the counter; at 0 go to IDLE. `sync_pulse` is ignored throughout STEP and SETTLE.
- Only one antenna's `int_delay` changes per STEP. Other antennas stay constant.
- Reset asserted mid-operation immediately returns all state to reset values. Any partially applied delay is discarded to 0.

## Timing
- `sync_pulse` sampled high in IDLE at cycle t:
  - STEP at t+1.
  - New `int_delay[k]` and `upd_done[k]` visible at t+2.
  - SETTLE occupies t+2 .. t+1+SETTLE_CYC.
  - IDLE at t+2+SETTLE_CYC. The earliest next accepted strobe is in that cycle.
- `dly_busy` is high from t+1 through t+1+SETTLE_CYC.
- `cfg_ready` is low only in the STEP cycle. Writes in SETTLE are accepted and take effect from the next STEP evaluation.
- All outputs are registered except `cfg_ready`, which decodes directly from the FSM register.

## Configuration
- `JB_DFE_INT_DLY_STEP_LIMIT_EN` defined: each STEP changes a delay by at most MAX_STEP. Large changes take several boundaries.
- Not defined: STEP loads target[k] directly, so each antenna completes in a single STEP. MAX_STEP is unused.

## Test plan
- Reset, write ant2=5 (limit on, MAX_STEP=1), pulse sync every 40 cycles → int_delay[2] steps 1,2,3,4,5, one step per sync; upd_done[2] pulses once, with step 5.
- Write ant0=3, ant1=3, ant3=3, then syncs → service order 0,1,3,0,1,3,…; exactly one antenna changes per STEP; all reach 3.
- Write ant1=100, then ant1=−4 → clamps to 63 and 0; `err_clamp`=1. err_clr together with a new clamp keeps it 1; err_clr alone clears it.
- `sync_pulse` during SETTLE (SETTLE_CYC=16, pulse at t+5) → ignored, no change; pulse at t+18 → STEP at t+19.
- Macro undefined, write ant0=40, one sync → int_delay[0]=40 at t+2 with upd_done[0]. Write ant0=40 again → pending stays 0, no pulse.
- Assert resetn low while in SETTLE with int_delay[3]=7 → all `int_delay` 0, `dly_busy` 0, pending cleared immediately (asynchronously).
